memory_access_unit: RTL and testbench

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/memory_access_unit_pkg.sv | 23 ++
 rtl/memory_access_unit_lane.sv | 42 ++++
 rtl/memory_access_unit.sv | 127 ++++++++++++
 tb/tb_memory_access_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: access size codes,
// controller state encoding and the alignment rule.
package memory_access_unit_pkg;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;  // 2'b11 also decodes as byte

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_WORD: return (off != 2'b00);
      MEM_HALF: return off[0];
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_unit_lane.sv
// Byte-lane steering: store byte enables and data replication, load
// shift/mask into a right-aligned zero-filled value.
module mem_lane_align
  import memory_access_unit_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = w_shifted;
    case (i_size)
      MEM_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_shifted;
      end
      MEM_HALF: begin
        o_be    = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0000, w_shifted[15:0]};
      end
      default: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h000000, w_shifted[7:0]};
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Load/store bus controller: accepts one aligned access from the pipeline,
// holds it on the data bus until ack or timeout, then returns load data.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic [1:0]  i_memSize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_writeData,
  output logic        o_stall,
  output logic [31:0] o_readData,
  output logic        o_misaligned,
  output logic        o_busErr,
  output logic        o_dmemReq,
  output logic        o_dmemWe,
  output logic [31:0] o_dmemAddr,
  output logic [31:0] o_dmemWdata,
  output logic [3:0]  o_dmemBe,
  input  logic        i_dmemAck,
  input  logic [31:0] i_dmemRdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [29:0]        r_word_addr;
  logic               r_we;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [1:0]         r_size;
  logic [1:0]         r_off;
  logic [31:0]        r_rdata;

  logic               w_valid;
  logic               w_idle;
  logic               w_busy;
  logic               w_mis;
  logic               w_start;
  logic               w_timeout;
  logic [1:0]         w_lane_size;
  logic [1:0]         w_lane_off;
  logic [3:0]         w_lane_be;
  logic [31:0]        w_lane_wdata;
  logic [31:0]        w_lane_rdata;

  assign w_valid   = i_memRead | i_memWrite;
  assign w_idle    = (r_state == ST_IDLE);
  assign w_busy    = (r_state == ST_BUSY);
  assign w_mis     = w_idle & w_valid & is_misaligned(i_memSize, i_addr[1:0]);
  assign w_start   = w_idle & w_valid & ~w_mis;
  assign w_timeout = w_busy & ~i_dmemAck & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // One lane aligner serves both directions: live inputs while launching,
  // the registered size/offset while waiting for load data.
  assign w_lane_size = w_busy ? r_size : i_memSize;
  assign w_lane_off  = w_busy ? r_off  : i_addr[1:0];

  mem_lane_align u_lane (
    .i_size  (w_lane_size),
    .i_off   (w_lane_off),
    .i_wdata (i_writeData),
    .i_rdata (i_dmemRdata),
    .o_be    (w_lane_be),
    .o_wdata (w_lane_wdata),
    .o_rdata (w_lane_rdata)
  );

  assign o_stall      = w_start | w_busy;
  assign o_misaligned = w_mis;
  assign o_busErr     = w_timeout;
  assign o_dmemReq    = w_busy;
  assign o_dmemWe     = w_busy & r_we;
  assign o_dmemBe     = w_busy ? r_be : 4'b0000;
  assign o_dmemAddr   = {r_word_addr, 2'b00};
  assign o_dmemWdata  = r_wdata;
  assign o_readData   = r_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_word_addr <= '0;
      r_we        <= 1'b0;
      r_be        <= 4'b0000;
      r_wdata     <= '0;
      r_size      <= MEM_WORD;
      r_off       <= 2'b00;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_word_addr <= i_addr[31:2];
            r_we        <= i_memWrite;
            r_be        <= w_lane_be;
            r_wdata     <= w_lane_wdata;
            r_size      <= i_memSize;
            r_off       <= i_addr[1:0];
            r_cnt       <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_dmemAck) begin
            // Stores leave the last load result untouched.
            if (!r_we) r_rdata <= w_lane_rdata;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed vector table,
// randomized accesses against a byte-lane reference model, reset corner case.
module tb_memory_access_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead, memWrite;
  logic [1:0]  memSize;
  logic [31:0] addr, writeData;
  logic        stall, misaligned, busErr;
  logic [31:0] readData;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic [3:0]  dmemBe;
  logic        dmemAck;
  logic [31:0] dmemRdata;

  memory_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_memRead   (memRead),
    .i_memWrite  (memWrite),
    .i_memSize   (memSize),
    .i_addr      (addr),
    .i_writeData (writeData),
    .o_stall     (stall),
    .o_readData  (readData),
    .o_misaligned(misaligned),
    .o_busErr    (busErr),
    .o_dmemReq   (dmemReq),
    .o_dmemWe    (dmemWe),
    .o_dmemAddr  (dmemAddr),
    .o_dmemWdata (dmemWdata),
    .o_dmemBe    (dmemBe),
    .i_dmemAck   (dmemAck),
    .i_dmemRdata (dmemRdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_cyc;   // BUSY cycle (1-based) carrying ack; 0 = never
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn = 0;
  logic [31:0] last_rd = 32'h0;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an access covers nb consecutive byte lanes starting at
  // the address offset; it is misaligned when the offset is not a multiple of nb.
  function automatic vec_t model(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int ack_cyc);
    vec_t v;
    int nb;
    int off;
    nb  = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    off = int'(a[1:0]);
    v = '0;
    v.rd = rd; v.wr = wr; v.size = size; v.addr = a; v.wd = wd;
    v.rdata = rdata; v.ack_cyc = ack_cyc;
    v.exp_mis = (off % nb) != 0;
    for (int b = 0; b < 4; b++) begin
      v.exp_be[b] = (b >= off) && (b < off + nb);
      v.exp_wdata[8*b +: 8] = wd[8*(b % nb) +: 8];
    end
    for (int i = 0; i < nb; i++)
      if (off + i < 4) v.exp_rdata[8*i +: 8] = rdata[8*(off + i) +: 8];
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int          n_busy;
    logic [31:0] exp_rd;
    @(negedge clk);
    chk("hold_readData", readData, last_rd);
    memRead = v.rd; memWrite = v.wr; memSize = v.size;
    addr = v.addr; writeData = v.wd; dmemAck = 1'b0;
    #1;
    chk("idle_misaligned", misaligned, v.exp_mis);
    chk("idle_req", dmemReq, 1'b0);
    if (v.exp_mis) begin
      chk("mis_stall", stall, 1'b0);
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0;
      #1;
      chk("mis_pulse_end", {misaligned, dmemReq, stall}, 3'b000);
      $display("txn %0d rd=%0b wr=%0b size=%0d addr=%h misaligned", n_txn, v.rd, v.wr, v.size, v.addr);
      n_txn++;
      return;
    end
    chk("idle_stall", stall, 1'b1);
    n_busy = (v.ack_cyc == 0) ? TO : v.ack_cyc;
    for (int i = 1; i <= n_busy; i++) begin
      @(negedge clk);
      dmemAck   = (i == v.ack_cyc);
      dmemRdata = dmemAck ? v.rdata : $urandom;
      #1;
      chk("busy_req_stall", {dmemReq, stall}, 2'b11);
      chk("busy_bus", {dmemWe, dmemBe, dmemAddr, dmemWdata},
          {v.wr, v.exp_be, v.addr & 32'hFFFF_FFFC, v.exp_wdata});
      chk("busy_busErr", busErr, (v.ack_cyc == 0) && (i == n_busy));
    end
    @(negedge clk);
    dmemAck = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    #1;
    exp_rd = (v.ack_cyc == 0) ? 32'h0 : (v.wr ? last_rd : v.exp_rdata);
    chk("done_readData", readData, exp_rd);
    chk("done_flags", {stall, dmemReq, busErr, dmemWe, dmemBe}, 8'h00);
    last_rd = exp_rd;
    $display("txn %0d rd=%0b wr=%0b size=%0d addr=%h ack=%0d readData=%h", n_txn, v.rd, v.wr,
             v.size, v.addr, v.ack_cyc, readData);
    n_txn++;
  endtask

  initial begin
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; memSize = 2'b00;
    addr = '0; writeData = '0; dmemAck = 1'b0; dmemRdata = '0;
    #2;
    chk("reset_outputs", {stall, misaligned, busErr, dmemReq, dmemWe, dmemBe, readData},
        {9'h000, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    dmemAck = 1'b1;  // ack while idle must be ignored
    #1;
    chk("idle_ack_ignored", {dmemReq, stall}, 2'b00);
    @(negedge clk);
    dmemAck = 1'b0;
    #1;
    chk("idle_ack_readData", readData, 32'h0);

    //            rd wr size   addr          wd            rdata         ack mis be       wdata         rdata_exp
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 32'h100, 32'h0,        32'hDEADBEEF, 3,  1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 2'b10, 32'h103, 32'h0,        32'h80112233, 1,  1'b0, 4'b1000, 32'h0,        32'h00000080};
    tbl[2]  = '{1'b0, 1'b1, 2'b01, 32'h202, 32'h0000ABCD, 32'h0,        2,  1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 32'h101, 32'h0,        32'h0,        1,  1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 1'b1, 2'b01, 32'h203, 32'h1234,     32'h0,        1,  1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 1'b0, 2'b10, 32'h201, 32'h0,        32'hAABBCCDD, 2,  1'b0, 4'b0010, 32'h0,        32'h000000CC};
    tbl[6]  = '{1'b1, 1'b0, 2'b01, 32'h102, 32'h0,        32'h12345678, 1,  1'b0, 4'b1100, 32'h0,        32'h00001234};
    tbl[7]  = '{1'b1, 1'b1, 2'b00, 32'h300, 32'h11223344, 32'hFFFFFFFF, 1,  1'b0, 4'b1111, 32'h11223344, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 2'b00, 32'h400, 32'h0,        32'h0,        0,  1'b0, 4'b1111, 32'h0,        32'h0};
    tbl[9]  = '{1'b1, 1'b0, 2'b00, 32'h404, 32'h0,        32'hCAFEF00D, TO, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D};
    tbl[10] = '{1'b0, 1'b1, 2'b11, 32'h002, 32'h0000005A, 32'h0,        1,  1'b0, 4'b0100, 32'h5A5A5A5A, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 2'b01, 32'h000, 32'h0,        32'h8765FFEE, 1,  1'b0, 4'b0011, 32'h0,        32'h0000FFEE};
    for (int k = 0; k < 12; k++) run_vec(tbl[k]);

    // Reset in the middle of a bus transaction, then a stray late ack.
    @(negedge clk);
    memRead = 1'b1; memSize = 2'b00; addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_req", dmemReq, 1'b1);
    rst_n = 1'b0;
    memRead = 1'b0;
    #1;
    chk("reset_busy_outputs", {dmemReq, stall, busErr, dmemWe, dmemBe}, 8'h00);
    chk("reset_busy_readData", readData, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; dmemAck = 1'b1; dmemRdata = 32'h13579BDF;
    #1;
    chk("late_ack_req", {dmemReq, stall}, 2'b00);
    @(negedge clk);
    dmemAck = 1'b0;
    #1;
    chk("late_ack_readData", readData, 32'h0);
    $display("txn %0d reset mid-busy with late ack", n_txn);
    n_txn++;

    for (int k = 0; k < 40; k++) begin
      logic        rd, wr;
      int          ack;
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      if (!rd && !wr) rd = 1'b1;
      ack = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
      run_vec(model(rd, wr, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, ack));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
